add64_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs a 64-bit add or subtract by time-sharing one 32-bit ripple adder slice (fulladder_32bit) over two cycles: low word first, then high word with the registered carry. It uses a start/busy/done handshake and produces registered results with carry-out and signed-overflow flags. It replaces the combinational 64-bit adder wherever area matters more than latency.

---
 rtl/add64_seq_ctrl_pkg.sv | 29 ++
 rtl/add64_seq_ctrl_fa32.sv | 32 +++
 rtl/add64_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_add64_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add64_seq_ctrl_pkg.sv
// add64_seq_ctrl_pkg
//   Shared definitions for the two-cycle 64-bit add/subtract sequencer:
//   datapath widths, FSM state encoding and the operand-conditioning helper.
//   No ports (package).
package add64_seq_ctrl_pkg;

  localparam int DW = 64;  // operand / result width
  localparam int SW = 32;  // width of the shared adder slice

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Returns {cin_eff, b_eff}. Subtraction is a + ~b + 1, so the external
  // carry-in is deliberately discarded when sub is set.
  function automatic logic [DW:0] eff_operand(input logic [DW-1:0] b,
                                              input logic          ci,
                                              input logic          sub);
    logic [DW-1:0] b_eff;
    logic          cin_eff;
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : ci;
    return {cin_eff, b_eff};
  endfunction

endpackage

// File: rtl/add64_seq_ctrl_fa32.sv
// fulladder_32bit
//   Purely combinational 32-bit ripple-carry adder slice. It is time-shared
//   by add64_seq_ctrl for the low and high words of a 64-bit operation.
// Ports:
//   a   in  SW  addend
//   b   in  SW  addend
//   ci  in  1   carry into bit 0
//   s   out SW  sum
//   co  out 1   carry out of bit SW-1
module fulladder_32bit
  import add64_seq_ctrl_pkg::*;
(
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < SW; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    co = carry;
  end

endmodule

// File: rtl/add64_seq_ctrl.sv
// add64_seq_ctrl
//   Two-cycle 64-bit add/subtract sequencer built around a single 32-bit
//   adder slice: low word in LO, high word (with the registered carry) in
//   HI. Results, carry-out and signed overflow are registered and only
//   change on the HI->DONE edge.
// Ports:
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   start  in  1   operation request, honoured only when busy=0
//   a      in  DW  operand A (latched on accepted start)
//   b      in  DW  operand B (latched on accepted start)
//   ci     in  1   carry-in for add, ignored for subtract
//   sub    in  1   1 = a - b
//   busy   out 1   operation in progress (LO, HI)
//   done   out 1   one-cycle pulse, results valid
//   sum    out DW  registered result (modulo 2^64)
//   Cout   out 1   carry out of bit 63 (subtract: 1 = no borrow)
//   ovf    out 1   signed overflow
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// LO    | slice adds low words, low sum and carry are captured
// HI    | slice adds high words, full result and flags are captured
// DONE  | done pulse; a new start is accepted here without idling
module add64_seq_ctrl
  import add64_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          ci,
  input  logic          sub,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          Cout,
  output logic          ovf
);

  state_t        state_q, state_d;

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;        // already conditioned (b or ~b)
  logic          cin_q;
  logic          carry_q;    // carry out of the low word
  logic [SW-1:0] sum_lo_q;
  logic [DW-1:0] sum_q;
  logic          cout_q;
  logic          ovf_q;

  logic          accept;
  logic [DW:0]   eff;

  logic [SW-1:0] slice_a;
  logic [SW-1:0] slice_b;
  logic          slice_ci;
  logic [SW-1:0] slice_s;
  logic          slice_co;
  logic          carry_into_msb;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign eff    = eff_operand(b, ci, sub);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LO : IDLE;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = start ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      LO:      busy = 1'b1;
      HI:      busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Slice input mux. Outside HI the low half of the latched operands is
  // presented, so the slice only ever sees register values (never raw,
  // possibly-X inputs).
  always_comb begin
    slice_a  = a_q[SW-1:0];
    slice_b  = b_q[SW-1:0];
    slice_ci = cin_q;
    if (state_q == HI) begin
      slice_a  = a_q[DW-1:SW];
      slice_b  = b_q[DW-1:SW];
      slice_ci = carry_q;
    end
  end

  fulladder_32bit u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (slice_ci),
    .s  (slice_s),
    .co (slice_co)
  );

  // Recover the carry into bit 63 from its sum bit: s = a ^ b ^ c.
  assign carry_into_msb = a_q[DW-1] ^ b_q[DW-1] ^ slice_s[SW-1];

  // Operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      sum_lo_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= eff[DW-1:0];
        cin_q <= eff[DW];
      end
      if (state_q == LO) begin
        sum_lo_q <= slice_s;
        carry_q  <= slice_co;
      end
      if (state_q == HI) begin
        sum_q  <= {slice_s, sum_lo_q};
        cout_q <= slice_co;
        ovf_q  <= carry_into_msb ^ slice_co;
      end
    end
  end

  assign sum  = sum_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// tb_add64_seq_ctrl
//   Directed self-checking bench for add64_seq_ctrl. Inputs are driven and
//   outputs sampled on the falling edge of clk.
module tb_add64_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        sub;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        Cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  add64_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic        vci;
    logic        vsub;
    logic [63:0] vs;
    logic        vco;
    logic        vov;
  } vec_t;

  vec_t vecs[5];

  // Drives start for exactly one cycle; returns on the first falling edge
  // after the accepting rising edge (state LO).
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb,
                          input logic tci, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges since the start was driven until done is seen.
  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #12;
    checks++;
    if ({busy, done, Cout, ovf} !== 4'b0000 || sum !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h Cout=%b ovf=%b, required all 0",
               busy, done, sum, Cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_carry_boundary();
    start_op(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0);
    // LO
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 64'd0) begin
      errors++;
      $display("FAIL cb_lo: busy=%b done=%b sum=%h, required 1 0 0", busy, done, sum);
    end
    @(negedge clk);
    // HI
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 64'd0) begin
      errors++;
      $display("FAIL cb_hi: busy=%b done=%b sum=%h, required 1 0 0", busy, done, sum);
    end
    @(negedge clk);
    // DONE, three cycles after start
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL cb_done_timing: busy=%b done=%b, required 0 1", busy, done);
    end
    checks++;
    if (sum !== 64'h00000001_00000000 || Cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL cb_result: sum=%h Cout=%b ovf=%b, required 0000000100000000 0 0",
               sum, Cout, ovf);
    end
    a = '1; b = '1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 64'h00000001_00000000) begin
      errors++;
      $display("FAIL cb_hold: done=%b busy=%b sum=%h, required 0 0 0000000100000000",
               done, busy, sum);
    end
  endtask

  task automatic test_vectors();
    int cyc;
    bit to;
    vecs[0] = '{64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1};
    vecs[3] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vci, vecs[i].vsub);
      wait_done(cyc, to);
      checks++;
      if (to || cyc != 3) begin
        errors++;
        $display("FAIL vec%0d_latency: done after %0d cycles (timeout=%0b), required 3", i, cyc, to);
      end
      checks++;
      if (sum !== vecs[i].vs || Cout !== vecs[i].vco || ovf !== vecs[i].vov) begin
        errors++;
        $display("FAIL vec%0d_result: sum=%h Cout=%b ovf=%b, required %h %b %b",
                 i, sum, Cout, ovf, vecs[i].vs, vecs[i].vco, vecs[i].vov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    start_op(64'd1, 64'd2, 1'b0, 1'b0);
    // now in LO: try to inject a second operation
    a = 64'd100; b = 64'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ign_hi: busy=%b done=%b, required 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 64'd3) begin
      errors++;
      $display("FAIL ign_result: done=%b sum=%h, required 1 3", done, sum);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 64'd1; b = 64'd2; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);              // LO of first op
    a = 64'd10; b = 64'd20;      // start stays high
    @(negedge clk);              // HI
    @(negedge clk);              // DONE
    checks++;
    if (done !== 1'b1 || sum !== 64'd3) begin
      errors++;
      $display("FAIL b2b_first: done=%b sum=%h, required 1 3", done, sum);
    end
    @(negedge clk);              // must already be LO of second op
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b done=%b, required 1 0", busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 64'd30 || Cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b sum=%h Cout=%b ovf=%b, required 1 1e 0 0",
               done, sum, Cout, ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen_done;
    start_op(64'd1, 64'd1, 1'b0, 1'b0);
    @(negedge clk);              // HI
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Cout, ovf} !== 4'b0000 || sum !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b sum=%h Cout=%b ovf=%b, required all 0",
               busy, done, sum, Cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: %0d cycles with busy/done set, required 0", seen_done);
    end
    checks++;
    if (dut.state_q !== 2'd0 || sum !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_idle: state=%0d sum=%h, required 0 0", dut.state_q, sum);
    end
  endtask

  initial begin
    test_reset();
    test_carry_boundary();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
